fb_arbiter: RTL and testbench

//   Shares the single-port framebuffer RAM between the VGA scan-out reader and a pixel writer.

---
 rtl/fb_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_fb_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Framebuffer port arbiter: scan-out reads take priority; queued pixel writes and the
// full-buffer clear sequencer use the RAM only in cycles without a scan-out request.
module fb_arbiter #(
    parameter int PIXEL_W    = 24,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = $clog2(WIDTH * HEIGHT)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               disp_req,
    input  logic [X_W-1:0]     disp_x,
    input  logic [Y_W-1:0]     disp_y,
    output logic               disp_valid,
    output logic [PIXEL_W-1:0] disp_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [X_W-1:0]     wr_x,
    input  logic [Y_W-1:0]     wr_y,
    input  logic [PIXEL_W-1:0] wr_data,
    output logic               wr_oob,
    input  logic               clear_req,
    input  logic [PIXEL_W-1:0] clear_color,
    output logic               clear_busy,
    output logic               clear_done,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [PIXEL_W-1:0] mem_wdata,
    input  logic [PIXEL_W-1:0] mem_rdata
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

    state_t              state_q, state_d;
    logic [PIXEL_W-1:0]  color_q, color_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                done_q, done_d;
    logic                wr_oob_q, wr_oob_d;
    logic                disp_valid_q, disp_valid_d;
    logic                disp_zero_q, disp_zero_d;
    logic [PIXEL_W-1:0]  disp_hold_q, disp_hold_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;

    logic [ADDR_W-1:0]   fifo_addr_mem [FIFO_DEPTH];
    logic [PIXEL_W-1:0]  fifo_data_mem [FIFO_DEPTH];

    logic                disp_in, wr_in, fifo_empty, fifo_full;
    logic                push, pop, clr_wr;
    logic [ADDR_W-1:0]   disp_addr, wr_addr;
    logic [PIXEL_W-1:0]  disp_cur;

    assign disp_in   = (int'(disp_x) < WIDTH) && (int'(disp_y) < HEIGHT);
    assign wr_in     = (int'(wr_x) < WIDTH) && (int'(wr_y) < HEIGHT);
    assign disp_addr = ADDR_W'(int'(disp_y) * WIDTH + int'(disp_x));
    assign wr_addr   = ADDR_W'(int'(wr_y) * WIDTH + int'(wr_x));

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));

    // Ready looks only at registered state so the writer never sees a combinational path.
    assign wr_ready = !reset && !fifo_full && (state_q == S_IDLE);
    assign push     = wr_valid && wr_ready && wr_in;
    assign pop      = !disp_req && !fifo_empty && (state_q == S_IDLE || state_q == S_DRAIN);
    assign clr_wr   = !disp_req && (state_q == S_CLEAR);

    assign disp_cur   = disp_valid_q ? (disp_zero_q ? '0 : mem_rdata) : disp_hold_q;
    assign disp_data  = reset ? '0 : disp_cur;
    assign disp_valid = disp_valid_q;
    assign wr_oob     = wr_oob_q;
    assign clear_done = done_q;
    assign clear_busy = (state_q != S_IDLE);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (disp_req) begin
                mem_en   = disp_in;
                mem_addr = disp_in ? disp_addr : '0;
            end else if (pop) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fifo_addr_mem[rd_ptr_q];
                mem_wdata = fifo_data_mem[rd_ptr_q];
            end else if (clr_wr) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = color_q;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        color_d      = color_q;
        clr_cnt_d    = clr_cnt_q;
        done_d       = 1'b0;
        wr_oob_d     = wr_valid && wr_ready && !wr_in;
        disp_valid_d = disp_req;
        disp_zero_d  = disp_req && !disp_in;
        disp_hold_d  = disp_cur;
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_DRAIN;
                    color_d = clear_color;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                if (clr_wr) begin
                    if (clr_cnt_q == ADDR_W'(NPIX - 1)) begin
                        state_d   = S_IDLE;
                        clr_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            color_q      <= '0;
            clr_cnt_q    <= '0;
            done_q       <= 1'b0;
            wr_oob_q     <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_zero_q  <= 1'b0;
            disp_hold_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            color_q      <= color_d;
            clr_cnt_q    <= clr_cnt_d;
            done_q       <= done_d;
            wr_oob_q     <= wr_oob_d;
            disp_valid_q <= disp_valid_d;
            disp_zero_q  <= disp_zero_d;
            disp_hold_q  <= disp_hold_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy and pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= wr_addr;
            fifo_data_mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized bench for fb_arbiter: a queue/array model of the framebuffer, write queue
// and clear sweep predicts every RAM access and every handshake/status output.
module tb_fb_arbiter;
    localparam int PW     = 24;
    localparam int W      = 20;
    localparam int H      = 12;
    localparam int N      = W * H;
    localparam int DEPTH  = 4;
    localparam int AW     = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_req = 1'b0;
    logic [9:0]    disp_x = '0, disp_y = '0;
    logic          disp_valid;
    logic [PW-1:0] disp_data;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [9:0]    wr_x = '0, wr_y = '0;
    logic [PW-1:0] wr_data = '0;
    logic          wr_oob;
    logic          clear_req = 1'b0;
    logic [PW-1:0] clear_color = '0;
    logic          clear_busy, clear_done;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_wdata;
    logic [PW-1:0] mem_rdata = '0;

    fb_arbiter #(.PIXEL_W(PW), .WIDTH(W), .HEIGHT(H), .X_W(10), .Y_W(10),
                 .FIFO_DEPTH(DEPTH)) dut (
        .clock(clk), .reset(rst),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .wr_oob(wr_oob),
        .clear_req(clear_req), .clear_color(clear_color),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Environment RAM and the model's view of what the framebuffer should hold.
    int ram [N];
    int fb  [N];
    int qa[$];
    int qd[$];
    bit m_drain, m_clear, m_oob, m_done, m_dvalid;
    int m_idx, m_color, m_ddata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit dr, input int dx, input int dy, input bit wv,
                         input int wx, input int wy, input int wd,
                         input bit cr, input int cc);
        disp_req    = dr;
        disp_x      = 10'(dx);
        disp_y      = 10'(dy);
        wr_valid    = wv;
        wr_x        = 10'(wx);
        wr_y        = 10'(wy);
        wr_data     = PW'(wd);
        clear_req   = cr;
        clear_color = PW'(cc);
    endtask

    // Entered just after a negedge with inputs driven; returns at the next negedge.
    task automatic step();
        bit din, win, rdy, ee, ew, busy, d_en, d_we;
        int da, wa, ea, ewd, d_addr, d_wdata;
        #1;
        din = (int'(disp_x) < W) && (int'(disp_y) < H);
        win = (int'(wr_x) < W) && (int'(wr_y) < H);
        da  = int'(disp_y) * W + int'(disp_x);
        wa  = int'(wr_y) * W + int'(wr_x);
        rdy = 0; ee = 0; ew = 0; ea = 0; ewd = 0; busy = 0;
        if (!rst) begin
            rdy  = !m_drain && !m_clear && (qa.size() < DEPTH);
            busy = m_drain || m_clear;
            if (disp_req) begin
                ee = din; ea = da;
            end else if (qa.size() > 0 && !m_clear) begin
                ee = 1; ew = 1; ea = qa[0]; ewd = qd[0];
            end else if (m_clear) begin
                ee = 1; ew = 1; ea = m_idx; ewd = m_color;
            end
        end
        chk("wr_ready", 32'(wr_ready), 32'(rdy));
        chk("mem_en", 32'(mem_en), 32'(ee));
        chk("mem_we", 32'(mem_we), 32'(ew));
        if (ee) chk("mem_addr", 32'(mem_addr), 32'(ea));
        if (ew) chk("mem_wdata", 32'(mem_wdata), 32'(ewd));
        chk("disp_valid", 32'(disp_valid), rst ? 32'd0 : 32'(m_dvalid));
        chk("disp_data", 32'(disp_data), rst ? 32'd0 : 32'(m_ddata));
        chk("wr_oob", 32'(wr_oob), rst ? 32'd0 : 32'(m_oob));
        chk("clear_done", 32'(clear_done), rst ? 32'd0 : 32'(m_done));
        chk("clear_busy", 32'(clear_busy), 32'(busy));
        d_en = mem_en; d_we = mem_we; d_addr = int'(mem_addr); d_wdata = int'(mem_wdata);

        @(posedge clk);
        #1;
        if (d_en && d_addr < N) begin
            if (d_we) ram[d_addr] = d_wdata;
            else      mem_rdata = PW'(ram[d_addr]);
        end

        if (rst) begin
            qa.delete(); qd.delete();
            m_drain = 0; m_clear = 0; m_idx = 0; m_oob = 0; m_done = 0;
            m_dvalid = 0; m_ddata = 0;
        end else begin
            bit was_empty;
            was_empty = (qa.size() == 0);
            m_dvalid  = disp_req;
            if (disp_req) m_ddata = din ? fb[da] : 0;
            m_oob  = wr_valid && rdy && !win;
            m_done = 0;
            if (!disp_req && !was_empty && !m_clear) begin
                fb[qa[0]] = qd[0];
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (wr_valid && rdy && win) begin
                qa.push_back(wa);
                qd.push_back(int'(wr_data));
            end
            if (m_clear) begin
                if (!disp_req) begin
                    fb[m_idx] = m_color;
                    if (m_idx == N - 1) begin
                        m_clear = 0; m_done = 1; m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (m_drain) begin
                if (was_empty) begin
                    m_drain = 0; m_clear = 1; m_idx = 0;
                end
            end else if (clear_req) begin
                m_drain = 1; m_color = int'(clear_color);
            end
        end
        @(negedge clk);
    endtask

    function automatic int rcoord(input int lim);
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 700;
        return int'($urandom_range(0, lim + 1));
    endfunction

    initial begin
        bit seen;
        int pct;
        for (int i = 0; i < N; i++) begin
            ram[i] = int'($urandom_range(0, 24'hFFFFFF));
            fb[i]  = ram[i];
        end
        m_drain = 0; m_clear = 0; m_idx = 0; m_color = 0;
        m_oob = 0; m_done = 0; m_dvalid = 0; m_ddata = 0;

        @(negedge clk);
        drive(1, 1, 1, 1, 3, 2, 5, 1, 7);
        repeat (2) step();
        rst = 1'b0;

        // First write after reset lands at y*W+x on the following cycle.
        drive(0, 0, 0, 1, 3, 2, 24'hFF0000, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("t1_ram", 32'(ram[2 * W + 3]), 32'hFF0000);

        // Scan-out hogs the RAM while the writer fills the queue, then drains in order.
        for (int i = 0; i < 10; i++) begin
            drive(1, i, 1, 1, i + 1, 3, 24'h100 + i, 0, 0);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end

        // Reads at the last pixel and just past the right edge.
        drive(1, W - 1, H - 1, 0, 0, 0, 0, 0, 0); step();
        drive(1, W, 0, 0, 0, 0, 0, 0, 0);         step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);         step();

        // Out-of-range write is accepted and dropped.
        drive(0, 0, 0, 1, 700, 10, 24'hABCDEF, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);             step();
        step();

        // Two queued writes, then a clear under alternating scan-out load.
        drive(1, 2, 2, 1, 4, 4, 24'h111111, 0, 0); step();
        drive(1, 2, 2, 1, 5, 4, 24'h222222, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 24'h000080); step();
        seen = 0;
        for (int i = 0; i < 6 * N && !seen; i++) begin
            drive(i % 2 == 0, i % W, 0, 0, 0, 0, 0, 0, 0);
            step();
            seen = clear_done;
        end
        chk("t5_done_seen", 32'(seen), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("t5_ram_color", 32'(ram[N - 1]), 32'h000080);

        // Reset in the middle of a clear aborts it without further writes.
        drive(0, 0, 0, 1, 1, 1, 24'h333333, 1, 24'h00FF00); step();
        seen = 0;
        for (int i = 0; i < 8 * N && !seen; i++) begin
            drive($urandom_range(0, 1) == 1, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
            seen = m_clear && (m_idx >= N / 2);
        end
        chk("t6_reached_mid_clear", 32'(seen), 32'd1);
        drive(1, 1, 1, 1, 2, 2, 24'h444444, 0, 0);
        #3 rst = 1'b1;
        #1;
        chk("t6_async_mem_en", 32'(mem_en), 32'd0);
        chk("t6_async_mem_we", 32'(mem_we), 32'd0);
        chk("t6_async_ready", 32'(wr_ready), 32'd0);
        chk("t6_async_busy", 32'(clear_busy), 32'd0);
        chk("t6_async_disp_valid", 32'(disp_valid), 32'd0);
        @(negedge clk);
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end

        // Random traffic with varying scan-out load and occasional clears.
        pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 40 == 0) pct = int'($urandom_range(0, 2)) * 40 + 10;
            drive(int'($urandom_range(0, 99)) < pct, rcoord(W), rcoord(H),
                  $urandom_range(0, 2) != 0, rcoord(W), rcoord(H),
                  int'($urandom_range(0, 24'hFFFFFF)),
                  $urandom_range(0, 399) == 0, int'($urandom_range(0, 24'hFFFFFF)));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
